// File: rtl/pending_bit_drain_if.sv
// Handshake bundle for pending_bit_drain: event/flush inputs from the producer side,
// issued-index valid/ready port and the live pending bitmap back from the drain.
interface pending_bit_drain_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0] set;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [WIDTH-1:0] pending;

    modport master (
        output set, flush, out_ready,
        input  out_valid, out_idx, pending
    );

    modport slave (
        input  set, flush, out_ready,
        output out_valid, out_idx, pending
    );
endinterface

// File: rtl/pending_bit_drain.sv
// Pending-bit drain: captures per-index event pulses into a bitmap and issues one
// pending index per cycle over valid/ready, clearing each bit as it is issued.
module pending_bit_drain #(
    parameter int                WIDTH       = 16,
    parameter int                IDX_W       = $clog2(WIDTH),
    parameter bit                ROUND_ROBIN = 1'b1,
    parameter logic [WIDTH-1:0]  RST_PENDING = '0
) (
    input  logic               clk,
    input  logic               rst,
    pending_bit_drain_if.slave bus_io
);
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [WIDTH-1:0] candidates;
    logic             slot_free;
    logic [IDX_W-1:0] search_start;
    logic [IDX_W-1:0] sel;
    logic [WIDTH-1:0] sel_onehot;

    function automatic logic [IDX_W-1:0] first_from(
        input logic [WIDTH-1:0] vec,
        input logic [IDX_W-1:0] start
    );
        logic [IDX_W-1:0] found;
        int               pos;
        found = '0;
        // Walk the search order backwards so the earliest hit is the one left standing.
        for (int k = WIDTH - 1; k >= 0; k--) begin
            pos = (int'(start) + k) % WIDTH;
            if (vec[pos]) found = pos[IDX_W-1:0];
        end
        return found;
    endfunction

    assign candidates   = pending_q | bus_io.set;
    assign slot_free    = ~out_valid_q | bus_io.out_ready;
    assign search_start = ROUND_ROBIN ? rr_ptr_q : '0;
    assign sel          = first_from(candidates, search_start);

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path can infer a latch.
        pending_d   = candidates;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (bus_io.flush) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
        end else if (slot_free) begin
            if (|candidates) begin
                out_valid_d = 1'b1;
                out_idx_d   = sel;
                pending_d   = candidates & ~sel_onehot;
                rr_ptr_d    = (sel == IDX_W'(WIDTH - 1)) ? '0 : sel + 1'b1;
            end else begin
                out_valid_d = 1'b0;
                pending_d   = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= RST_PENDING;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_idx   = out_idx_q;
    assign bus_io.pending   = pending_q;
endmodule

// File: tb/tb_pending_bit_drain.sv
// Bench for pending_bit_drain: a round-robin and a lowest-first instance share stimulus
// and are compared every cycle against a bitmap-level reference model.
module tb_pending_bit_drain;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic [W-1:0] set_s   = '0;
    logic         flush_s = 1'b0;
    logic         ready_s = 1'b0;
    logic         rst_s   = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pending_bit_drain_if #(.WIDTH(W)) if_rr ();
    pending_bit_drain_if #(.WIDTH(W)) if_lo ();

    assign if_rr.set       = set_s;
    assign if_rr.flush     = flush_s;
    assign if_rr.out_ready = ready_s;
    assign if_lo.set       = set_s;
    assign if_lo.flush     = flush_s;
    assign if_lo.out_ready = ready_s;

    pending_bit_drain #(.WIDTH(W), .ROUND_ROBIN(1'b1), .RST_PENDING(16'h0000)) dut_rr (
        .clk    (clk),
        .rst    (rst_s),
        .bus_io (if_rr.slave)
    );

    pending_bit_drain #(.WIDTH(W), .ROUND_ROBIN(1'b0), .RST_PENDING(16'h0000)) dut_lo (
        .clk    (clk),
        .rst    (rst_s),
        .bus_io (if_lo.slave)
    );

    // Reference state per instance: 0 = round-robin, 1 = lowest-index-first.
    logic [W-1:0] m_pend  [2];
    logic         m_valid [2];
    int           m_idx   [2];
    int           m_ptr   [2];
    string        names   [2] = '{"rr", "lo"};

    function automatic logic obs_valid(input int m);
        return (m == 0) ? if_rr.out_valid : if_lo.out_valid;
    endfunction

    function automatic logic [3:0] obs_idx(input int m);
        return (m == 0) ? if_rr.out_idx : if_lo.out_idx;
    endfunction

    function automatic logic [W-1:0] obs_pend(input int m);
        return (m == 0) ? if_rr.pending : if_lo.pending;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the abstract behaviour: merge events, pick the next index in search order.
    task automatic model_step(input int m);
        logic [W-1:0] cand;
        bit           found;
        int           start, pick;
        if (rst_s) begin
            m_pend[m]  = '0;
            m_valid[m] = 1'b0;
            m_idx[m]   = 0;
            m_ptr[m]   = 0;
        end else if (flush_s) begin
            m_pend[m]  = '0;
            m_valid[m] = 1'b0;
        end else begin
            cand = m_pend[m] | set_s;
            if (m_valid[m] && !ready_s) begin
                m_pend[m] = cand;
            end else if (cand == '0) begin
                m_valid[m] = 1'b0;
                m_pend[m]  = '0;
            end else begin
                start = (m == 0) ? m_ptr[m] : 0;
                found = 1'b0;
                pick  = 0;
                for (int k = 0; k < W; k++) begin
                    if (!found && cand[(start + k) % W]) begin
                        found = 1'b1;
                        pick  = (start + k) % W;
                    end
                end
                cand[pick] = 1'b0;
                m_pend[m]  = cand;
                m_valid[m] = 1'b1;
                m_idx[m]   = pick;
                m_ptr[m]   = (pick + 1) % W;
            end
        end
    endtask

    task automatic step(input logic [W-1:0] s, input logic f, input logic r, input logic rs);
        logic       held  [2];
        logic [3:0] hidx  [2];
        set_s   = s;
        flush_s = f;
        ready_s = r;
        rst_s   = rs;
        for (int m = 0; m < 2; m++) begin
            held[m] = obs_valid(m) && !r && !f && !rs;
            hidx[m] = obs_idx(m);
        end
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s.valid", names[m]), obs_valid(m), m_valid[m]);
            check($sformatf("%s.idx", names[m]), obs_idx(m), m_idx[m]);
            check($sformatf("%s.pending", names[m]), obs_pend(m), m_pend[m]);
            if (held[m]) begin
                check($sformatf("%s.stall_valid", names[m]), obs_valid(m), 1);
                check($sformatf("%s.stall_idx", names[m]), obs_idx(m), hidx[m]);
            end
        end
    endtask

    // Directed expectation written straight from the scenario, independent of the model.
    task automatic expect_out(input string tag, input logic v_rr, input int i_rr,
                              input logic v_lo, input int i_lo);
        check({tag, ".rr.valid"}, if_rr.out_valid, v_rr);
        check({tag, ".lo.valid"}, if_lo.out_valid, v_lo);
        if (v_rr) check({tag, ".rr.idx"}, if_rr.out_idx, i_rr);
        if (v_lo) check({tag, ".lo.idx"}, if_lo.out_idx, i_lo);
    endtask

    initial begin
        logic [W-1:0] rs_set, rnd_a, rnd_b;
        int           kind;

        // Reset, then idle.
        step('0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step('0, 1'b0, 1'b1, 1'b0);
            expect_out("t1.idle", 1'b0, 0, 1'b0, 0);
            check("t1.rr.pending", if_rr.pending, 16'h0000);
        end

        // Single event, one-cycle latency.
        step(16'h0001, 1'b0, 1'b1, 1'b0);
        expect_out("t2.issue", 1'b1, 0, 1'b1, 0);
        step('0, 1'b0, 1'b1, 1'b0);
        expect_out("t2.drain", 1'b0, 0, 1'b0, 0);

        // Back-to-back issue and pointer wrap.
        step('0, 1'b0, 1'b1, 1'b1);
        step(16'h8421, 1'b0, 1'b1, 1'b0);
        expect_out("t3.a", 1'b1, 0, 1'b1, 0);
        step('0, 1'b0, 1'b1, 1'b0);
        expect_out("t3.b", 1'b1, 5, 1'b1, 5);
        step('0, 1'b0, 1'b1, 1'b0);
        expect_out("t3.c", 1'b1, 10, 1'b1, 10);
        step('0, 1'b0, 1'b1, 1'b0);
        expect_out("t3.d", 1'b1, 15, 1'b1, 15);
        step(16'h0021, 1'b0, 1'b1, 1'b0);
        expect_out("t3.wrap0", 1'b1, 0, 1'b1, 0);
        step('0, 1'b0, 1'b1, 1'b0);
        expect_out("t3.wrap5", 1'b1, 5, 1'b1, 5);
        step('0, 1'b0, 1'b1, 1'b0);
        expect_out("t3.empty", 1'b0, 0, 1'b0, 0);

        // Re-pend of the held index under back-pressure.
        step('0, 1'b0, 1'b1, 1'b1);
        step(16'h0003, 1'b0, 1'b0, 1'b0);
        expect_out("t4.first", 1'b1, 0, 1'b1, 0);
        step(16'h0001, 1'b0, 1'b0, 1'b0);
        expect_out("t4.held", 1'b1, 0, 1'b1, 0);
        check("t4.rr.pending", if_rr.pending, 16'h0003);
        step('0, 1'b0, 1'b1, 1'b0);
        expect_out("t4.second", 1'b1, 1, 1'b1, 0);
        step('0, 1'b0, 1'b1, 1'b0);
        expect_out("t4.third", 1'b1, 0, 1'b1, 1);
        step('0, 1'b0, 1'b1, 1'b0);
        expect_out("t4.empty", 1'b0, 0, 1'b0, 0);

        // Flush drops pending bits, the held index and a same-cycle set.
        step('0, 1'b0, 1'b1, 1'b1);
        step(16'h00F8, 1'b0, 1'b0, 1'b0);
        expect_out("t5.held", 1'b1, 3, 1'b1, 3);
        check("t5.lo.pending", if_lo.pending, 16'h00F0);
        step(16'h0100, 1'b1, 1'b0, 1'b0);
        expect_out("t5.flushed", 1'b0, 0, 1'b0, 0);
        check("t5.rr.pending", if_rr.pending, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step('0, 1'b0, 1'b1, 1'b0);
            expect_out("t5.quiet", 1'b0, 0, 1'b0, 0);
        end

        // Random traffic against the reference model.
        step('0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10000; i++) begin
            kind  = $urandom_range(0, 3);
            rnd_a = W'($urandom);
            rnd_b = W'($urandom);
            case (kind)
                0:       rs_set = '0;
                1:       rs_set = W'(1) << $urandom_range(0, W - 1);
                2:       rs_set = rnd_a & rnd_b;
                default: rs_set = rnd_a;
            endcase
            step(rs_set,
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 999) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
